// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t : one 32-bit machine word (instruction, data or byte address)
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Instruction cache shared definitions: FSM state type, default geometry and
// helpers that derive the address field widths from the geometry.
// Address layout: {tag, idx, blkoff, 2'b00}.
package icache_pkg;
  typedef enum logic {IDLE, FILL} icache_state_t;

  localparam int DEF_WAYS     = 2;
  localparam int DEF_SETS     = 8;
  localparam int DEF_BLKWORDS = 2;

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  // Zero when a block holds a single word.
  function automatic int blkoff_width(input int blkwords);
    return $clog2(blkwords);
  endfunction

  function automatic int tag_width(input int sets, input int blkwords);
    return 30 - idx_width(sets) - blkoff_width(blkwords);
  endfunction

  // Vector widths cannot be zero; fields that vanish keep one dummy bit.
  function automatic int min1(input int w);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set tag, valid bit and a block of
// BLKWORDS data words.
// Ports:
//   i_clk, i_nrst            clock, synchronous active-low reset
//   i_flush                  clear every valid bit (wins over a write)
//   i_rd_idx/tag/off         lookup address fields
//   o_match, o_rdata         valid tag match at i_rd_idx, word at i_rd_off
//   i_wr_en/idx/tag/data     write a complete block and mark it valid
//   o_wr_valid               valid bit of set i_wr_idx (victim selection)
module icache_way
  import icache_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter  int SETS     = DEF_SETS,
  parameter  int BLKWORDS = DEF_BLKWORDS,
  localparam int IDX_W    = idx_width(SETS),
  localparam int TAG_W    = tag_width(SETS, BLKWORDS),
  localparam int CW       = min1(blkoff_width(BLKWORDS))
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  input  logic [CW-1:0]    i_rd_off,
  output logic             o_match,
  output word_t            o_rdata,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  word_t            i_wr_data [BLKWORDS],
  output logic             o_wr_valid
);
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  word_t            r_data [SETS][BLKWORDS];

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits qualify it.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && i_nrst && !i_flush) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      for (int b = 0; b < BLKWORDS; b++) begin
        r_data[i_wr_idx][b] <= i_wr_data[b];
      end
    end
  end

  assign o_match    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rdata    = r_data[i_rd_idx][i_rd_off];
  assign o_wr_valid = r_valid[i_wr_idx];
endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache between fetch and memory arbiter.
// Hits answer combinationally in the request cycle; a miss fills the whole
// block word by word, then the request hits on the following cycle.
// Ports:
//   CLK, nRST          clock, synchronous active-low reset
//   imemREN, imemaddr  fetch request and byte address (held until ihit)
//   iflush             invalidate all lines, abort any fill
//   ihit, imemload     fetch answer (imemload 0 when ihit=0)
//   iREN, iaddr        memory read request (iaddr 0 when iREN=0)
//   iwait, iload       memory busy / returned word
//   dbg_state          current FSM state
// Handshake: a memory word is accepted in every cycle with iREN=1 and
// iwait=0; while iwait=1 iREN and iaddr hold steady.
module icache_assoc
  import icache_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int WAYS     = DEF_WAYS,
  parameter int SETS     = DEF_SETS,
  parameter int BLKWORDS = DEF_BLKWORDS
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          imemREN,
  input  word_t         imemaddr,
  input  logic          iflush,
  output logic          ihit,
  output word_t         imemload,
  output logic          iREN,
  output word_t         iaddr,
  input  logic          iwait,
  input  word_t         iload,
  output icache_state_t dbg_state
);
  localparam int IDX_W  = idx_width(SETS);
  localparam int BOFF_W = blkoff_width(BLKWORDS);
  localparam int TAG_W  = tag_width(SETS, BLKWORDS);
  localparam int CW     = min1(BOFF_W);
  localparam int PW     = min1($clog2(WAYS));

  icache_state_t    r_state, w_state_next;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [CW-1:0]    r_cnt;
  word_t            r_buf  [BLKWORDS];
  logic [PW-1:0]    r_vptr [SETS];

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [CW-1:0]    w_off;
  logic             w_unused;
  logic [WAYS-1:0]  w_match, w_wr_valid, w_wr_en;
  word_t            w_rdata [WAYS];
  word_t            w_blk   [BLKWORDS];
  word_t            w_lookup, w_fill_addr;
  logic             w_any, w_hit, w_start, w_accept, w_last, w_commit;
  logic [PW-1:0]    w_victim;
  logic             w_found;

  assign w_tag    = imemaddr[31 -: TAG_W];
  assign w_idx    = imemaddr[2 + BOFF_W +: IDX_W];
  assign w_unused = ^imemaddr[1:0];

  if (BOFF_W > 0) begin : g_off
    assign w_off       = imemaddr[2 +: CW];
    assign w_fill_addr = {r_tag, r_idx, r_cnt, 2'b00};
  end else begin : g_nooff
    assign w_off       = '0;
    assign w_fill_addr = {r_tag, r_idx, 2'b00};
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(.SETS(SETS), .BLKWORDS(BLKWORDS)) u_way (
      .i_clk      (CLK),
      .i_nrst     (nRST),
      .i_flush    (iflush),
      .i_rd_idx   (w_idx),
      .i_rd_tag   (w_tag),
      .i_rd_off   (w_off),
      .o_match    (w_match[g]),
      .o_rdata    (w_rdata[g]),
      .i_wr_en    (w_wr_en[g]),
      .i_wr_idx   (r_idx),
      .i_wr_tag   (r_tag),
      .i_wr_data  (w_blk),
      .o_wr_valid (w_wr_valid[g])
    );
  end

  // At most one way matches, so OR-ing the qualified words is the mux.
  always_comb begin
    w_lookup = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_match[w]) w_lookup = w_lookup | w_rdata[w];
    end
  end

  assign w_any    = |w_match;
  assign w_hit    = (r_state == IDLE) && imemREN && w_any && !iflush;
  assign w_start  = (r_state == IDLE) && imemREN && !w_any && !iflush;
  assign w_accept = (r_state == FILL) && !iwait;
  assign w_last   = w_accept && (r_cnt == CW'(BLKWORDS - 1));
  assign w_commit = w_last && !iflush;

  // The final word bypasses the buffer so the block commits on that edge.
  always_comb begin
    for (int b = 0; b < BLKWORDS; b++) begin
      w_blk[b] = (b == BLKWORDS - 1) ? iload : r_buf[b];
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    w_victim = r_vptr[r_idx];
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !w_wr_valid[w]) begin
        w_victim = PW'(w);
        w_found  = 1'b1;
      end
    end
    w_wr_en = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_wr_en[w] = w_commit && (w_victim == PW'(w));
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_state_next = FILL;
      FILL: if (iflush || w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_tag <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      for (int s = 0; s < SETS; s++) r_vptr[s] <= '0;
    end else begin
      if (w_start) begin
        r_tag <= w_tag;
        r_idx <= w_idx;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // Pointer width is log2(WAYS), so the increment wraps modulo WAYS.
      if (w_commit && (WAYS > 1)) r_vptr[r_idx] <= r_vptr[r_idx] + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_buf[r_cnt] <= iload;
  end

  assign ihit      = w_hit;
  assign imemload  = w_hit ? w_lookup : '0;
  assign iREN      = (r_state == FILL);
  assign iaddr     = iREN ? w_fill_addr : '0;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;
  import icache_pkg::*;

  logic          clk = 1'b0;
  logic          nRST, imemREN, iflush, iwait;
  logic [31:0]   imemaddr, iload;
  logic          ihit, iREN;
  logic [31:0]   imemload, iaddr;
  icache_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache_assoc #(.WAYS(2), .SETS(8), .BLKWORDS(2)) dut (
    .CLK       (clk),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .iflush    (iflush),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dbg_state (dbg_state)
  );

  // Memory model: each word address returns a distinct value.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA0000 + a - 32'h40;
  endfunction
  assign iload = mem_word(iaddr);

  typedef struct {
    string       name;
    logic        nrst, ren;
    logic [31:0] addr;
    logic        flush, wt;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic nrst, input logic ren,
                     input logic [31:0] addr, input logic flush, input logic wt,
                     input logic e_hit, input logic [31:0] e_load,
                     input logic e_ren, input logic [31:0] e_iaddr);
    vec_t v;
    v.name = name; v.nrst = nrst; v.ren = ren; v.addr = addr;
    v.flush = flush; v.wt = wt; v.e_hit = e_hit; v.e_load = e_load;
    v.e_ren = e_ren; v.e_iaddr = e_iaddr;
    vecs.push_back(v);
  endtask

  task automatic t_idle();                         add("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_miss(input logic [31:0] a);     add("miss", 1, 1, a, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_hit(input logic [31:0] a);      add("hit",  1, 1, a, 0, 0, 1, mem_word(a), 0, 0); endtask
  task automatic t_fill(input logic [31:0] a, input logic wt, input logic [31:0] ea);
    add("fill", 1, 1, a, 0, wt, 0, 0, 1, ea);
  endtask

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // After reset: quiet outputs.
    t_idle();
    // Cold miss at 0x40 with three busy cycles.
    t_miss(32'h40);
    repeat (3) t_fill(32'h40, 1, 32'h40);
    t_fill(32'h40, 0, 32'h40);
    t_fill(32'h40, 0, 32'h44);
    t_hit(32'h40);
    t_hit(32'h44);
    t_idle();
    // Conflict traffic in set 0.
    t_miss(32'h80); t_fill(32'h80, 0, 32'h80); t_fill(32'h80, 0, 32'h84);
    t_hit(32'h80);
    t_hit(32'h40);
    t_miss(32'hC0); t_fill(32'hC0, 0, 32'hC0); t_fill(32'hC0, 0, 32'hC4);
    t_hit(32'hC0);
    t_hit(32'h80);
    t_miss(32'h40); t_fill(32'h40, 0, 32'h40); t_fill(32'h40, 0, 32'h44);
    t_hit(32'h40);
    t_miss(32'h80); t_fill(32'h80, 0, 32'h80); t_fill(32'h80, 0, 32'h84);
    t_hit(32'h80);
    t_hit(32'h40);
    // Long stall mid-fill; fetch address wanders during the fill.
    t_miss(32'h208); t_fill(32'h208, 0, 32'h208);
    repeat (5) t_fill(32'h300, 1, 32'h20C);
    t_fill(32'h208, 0, 32'h20C);
    t_hit(32'h208);
    t_hit(32'h20C);
    // Flush on the completing word of a fill.
    t_miss(32'h100); t_fill(32'h100, 0, 32'h100);
    add("flush_fill", 1, 1, 32'h100, 1, 0, 0, 0, 1, 32'h104);
    t_idle();
    t_miss(32'h40); t_fill(32'h40, 0, 32'h40); t_fill(32'h40, 0, 32'h44);
    t_hit(32'h40);
    add("flush_hit", 1, 1, 32'h40, 1, 0, 0, 0, 0, 0);
    t_miss(32'h100); t_fill(32'h100, 0, 32'h100); t_fill(32'h100, 0, 32'h104);
    t_hit(32'h100);
    // Reset in the middle of a fill.
    t_miss(32'h140); t_fill(32'h140, 0, 32'h140);
    add("rst_fill", 0, 1, 32'h140, 0, 0, 0, 0, 1, 32'h144);
    t_miss(32'h140); t_fill(32'h140, 0, 32'h140); t_fill(32'h140, 0, 32'h144);
    t_hit(32'h140);

    foreach (vecs[i]) begin
      nRST     = vecs[i].nrst;
      imemREN  = vecs[i].ren;
      imemaddr = vecs[i].addr;
      iflush   = vecs[i].flush;
      iwait    = vecs[i].wt;
      #1;
      check($sformatf("%0d_%s_ihit", i, vecs[i].name), {31'b0, ihit}, {31'b0, vecs[i].e_hit});
      check($sformatf("%0d_%s_imemload", i, vecs[i].name), imemload, vecs[i].e_load);
      check($sformatf("%0d_%s_iREN", i, vecs[i].name), {31'b0, iREN}, {31'b0, vecs[i].e_ren});
      check($sformatf("%0d_%s_iaddr", i, vecs[i].name), iaddr, vecs[i].e_iaddr);
      step();
    end

    // Ten idle cycles: nothing moves, and the line at 0x140 survives.
    nRST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b0; imemaddr = 32'h140;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("idle%0d_ihit", c), {31'b0, ihit}, 32'd0);
      check($sformatf("idle%0d_iREN", c), {31'b0, iREN}, 32'd0);
      check($sformatf("idle%0d_state", c), {31'b0, dbg_state == IDLE}, 32'd1);
      step();
    end
    imemREN = 1'b1;
    #1;
    check("post_idle_ihit", {31'b0, ihit}, 32'd1);
    check("post_idle_imemload", imemload, 32'hAAAA0100);
    step();
    imemREN = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
